// File: rtl/pwm_trip_zone_pkg.sv
// Shared types and default sizes for the PWM trip-zone protection stage.
package pwm_trip_zone_pkg;

    localparam int NFLT_DEF         = 4;
    localparam int FLTCNT_WIDTH_DEF = 16;

    typedef enum logic {
        TRIP_OFF = 1'b0,
        TRIP_ON  = 1'b1
    } trip_onoff_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        TRIPPED  = 2'd2,
        CLEARING = 2'd3
    } trip_state_e;

endpackage

// File: rtl/pwm_fault_filter.sv
// One external fault channel: 2-flop synchroniser, polarity match and
// saturating debounce counter compared against the live filter length.
module pwm_fault_filter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fault_in,
    input  logic          fault_pol,
    input  logic [CW-1:0] filt_len,
    output logic          qualified
);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          active;

    assign active = ~(sync_q[1] ^ fault_pol);

    always_comb begin
        cnt_d = '0;
        if (active)
            cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end

    // The counter holds the number of earlier active cycles, so filt_len = 0
    // qualifies on the very first synchronised-active cycle.
    assign qualified = active && (cnt_q >= filt_len);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], fault_in};
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_trip_zone.sv
// Trip-zone protection between the carrier PWM and the gate pins: debounced
// faults and shoot-through latch a trip that forces programmed safe levels.
module pwm_trip_zone
    import pwm_trip_zone_pkg::*;
#(
    parameter int NCH          = 8,
    parameter int NFLT         = NFLT_DEF,
    parameter int FLTCNT_WIDTH = FLTCNT_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    trip_onoff,
    input  logic [NFLT-1:0]         fault_in,
    input  logic [NFLT-1:0]         fault_pol,
    input  logic [NFLT-1:0]         fault_mask,
    input  logic [FLTCNT_WIDTH-1:0] filt_len,
    input  logic                    st_onoff,
    input  logic [NCH-1:0]          safe_A_x,
    input  logic [NCH-1:0]          safe_B_x,
    input  logic                    clear_req,
    input  logic [NCH-1:0]          pwm_A_in_x,
    input  logic [NCH-1:0]          pwm_B_in_x,
    output logic [NCH-1:0]          pwmout_A_x,
    output logic [NCH-1:0]          pwmout_B_x,
    output logic                    tripped,
    output logic [NFLT:0]           trip_cause,
    output logic                    trip_int
);

    logic [NFLT-1:0] qual;

    for (genvar g = 0; g < NFLT; g++) begin : g_flt
        pwm_fault_filter #(.CW(FLTCNT_WIDTH)) u_flt (
            .clk       (clk),
            .reset     (reset),
            .fault_in  (fault_in[g]),
            .fault_pol (fault_pol[g]),
            .filt_len  (filt_len),
            .qualified (qual[g])
        );
    end

    logic          st_hit, flt_hit, at_safe, force_safe;
    logic [NFLT:0] cause_now;

    assign st_hit    = st_onoff && |(pwm_A_in_x & pwm_B_in_x);
    assign flt_hit   = |(qual & ~fault_mask);
    assign cause_now = {st_hit, qual & ~fault_mask};
    assign at_safe   = (pwm_A_in_x == safe_A_x) && (pwm_B_in_x == safe_B_x);

    trip_state_e     state_q, state_d;
    logic [NFLT:0]   cause_q, cause_d;
    logic [NCH-1:0]  out_a_q, out_a_d, out_b_q, out_b_d;
    logic            int_q, int_d;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        if (trip_onoff == TRIP_OFF) begin
            state_d = IDLE;
            cause_d = '0;
        end else begin
            case (state_q)
                IDLE:  state_d = ARMED;
                ARMED: begin
                    if (|cause_now) begin
                        state_d = TRIPPED;
                        cause_d = cause_q | cause_now;
                    end
                end
                TRIPPED: begin
                    cause_d = cause_q | cause_now;
                    if (clear_req && !flt_hit)
                        state_d = CLEARING;
                end
                CLEARING: begin
                    // Resume only once the modulator sits at the safe levels,
                    // so the first pass-through cycle cannot emit a runt pulse.
                    if (flt_hit) begin
                        state_d = TRIPPED;
                        cause_d = cause_q | cause_now;
                    end else if (at_safe) begin
                        state_d = ARMED;
                        cause_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        int_d      = (state_d == TRIPPED) && (state_q != TRIPPED);
        force_safe = (state_d == TRIPPED) || (state_d == CLEARING);
        out_a_d    = force_safe ? safe_A_x : pwm_A_in_x;
        out_b_d    = force_safe ? safe_B_x : pwm_B_in_x;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cause_q <= '0;
            out_a_q <= '0;
            out_b_q <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            int_q   <= int_d;
        end
    end

    assign pwmout_A_x = out_a_q;
    assign pwmout_B_x = out_b_q;
    assign tripped    = (state_q == TRIPPED) || (state_q == CLEARING);
    assign trip_cause = cause_q;
    assign trip_int   = int_q;

endmodule

// File: tb/tb_pwm_trip_zone.sv
// Bench for pwm_trip_zone: vector table, directed trip/clear sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_pwm_trip_zone;

    localparam int NCH  = 8;
    localparam int NFLT = 4;
    localparam int CW   = 16;
    localparam int OW   = 2*NCH + NFLT + 3;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_TRIP  = 2;
    localparam int M_CLR   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, trip_onoff, st_onoff, clear_req;
    logic [NFLT-1:0] fault_in, fault_pol, fault_mask;
    logic [CW-1:0]   filt_len;
    logic [NCH-1:0]  safe_A_x, safe_B_x, pwm_A_in_x, pwm_B_in_x;
    logic [NCH-1:0]  pwmout_A_x, pwmout_B_x;
    logic            tripped, trip_int;
    logic [NFLT:0]   trip_cause;

    pwm_trip_zone #(.NCH(NCH), .NFLT(NFLT), .FLTCNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .trip_onoff (trip_onoff),
        .fault_in   (fault_in),
        .fault_pol  (fault_pol),
        .fault_mask (fault_mask),
        .filt_len   (filt_len),
        .st_onoff   (st_onoff),
        .safe_A_x   (safe_A_x),
        .safe_B_x   (safe_B_x),
        .clear_req  (clear_req),
        .pwm_A_in_x (pwm_A_in_x),
        .pwm_B_in_x (pwm_B_in_x),
        .pwmout_A_x (pwmout_A_x),
        .pwmout_B_x (pwmout_B_x),
        .tripped    (tripped),
        .trip_cause (trip_cause),
        .trip_int   (trip_int)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: pin history two edges deep, run length of active
    // cycles, trip mode, and the registered outputs it implies.
    int              m_mode;
    bit [NFLT-1:0]   m_d1, m_d2;
    int              m_run[NFLT];
    logic [NCH-1:0]  m_oa, m_ob;
    logic [NFLT:0]   m_cause;
    bit              m_int;

    function automatic logic [OW-1:0] dut_vec();
        return {pwmout_A_x, pwmout_B_x, tripped, trip_cause, trip_int};
    endfunction

    function automatic logic [OW-1:0] mk_vec(logic [NCH-1:0] a, logic [NCH-1:0] b,
                                             logic tr, logic [NFLT:0] c, logic i);
        return {a, b, tr, c, i};
    endfunction

    task automatic chk(string name, logic [OW-1:0] act, logic [OW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got A=%h B=%h tr=%b cause=%b int=%b, want A=%h B=%h tr=%b cause=%b int=%b",
                     name, act[OW-1 -: NCH], act[OW-1-NCH -: NCH], act[NFLT+2], act[NFLT+1:1], act[0],
                     exp[OW-1 -: NCH], exp[OW-1-NCH -: NCH], exp[NFLT+2], exp[NFLT+1:1], exp[0]);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic model_edge();
        bit [NFLT-1:0] act, qual;
        bit [NFLT:0]   now;
        bit            hit_f, safe;
        if (reset) begin
            m_mode = M_IDLE; m_d1 = '0; m_d2 = '0; m_oa = '0; m_ob = '0;
            m_cause = '0; m_int = 1'b0;
            for (int f = 0; f < NFLT; f++) m_run[f] = 0;
        end else begin
            for (int f = 0; f < NFLT; f++) begin
                act[f]  = (m_d2[f] == fault_pol[f]);
                qual[f] = act[f] && (m_run[f] >= int'(filt_len));
            end
            now   = {st_onoff && ((pwm_A_in_x & pwm_B_in_x) != '0), qual & ~fault_mask};
            hit_f = (qual & ~fault_mask) != '0;
            m_int = 1'b0;
            if (!trip_onoff) begin
                m_mode = M_IDLE; m_cause = '0;
            end else if (m_mode == M_IDLE) begin
                m_mode = M_ARMED;
            end else if (m_mode == M_ARMED) begin
                if (now != '0) begin m_mode = M_TRIP; m_cause |= now; m_int = 1'b1; end
            end else if (m_mode == M_TRIP) begin
                m_cause |= now;
                if (clear_req && !hit_f) m_mode = M_CLR;
            end else begin
                if (hit_f) begin
                    m_mode = M_TRIP; m_cause |= now; m_int = 1'b1;
                end else if (pwm_A_in_x == safe_A_x && pwm_B_in_x == safe_B_x) begin
                    m_mode = M_ARMED; m_cause = '0;
                end
            end
            safe = (m_mode == M_TRIP) || (m_mode == M_CLR);
            m_oa = safe ? safe_A_x : pwm_A_in_x;
            m_ob = safe ? safe_B_x : pwm_B_in_x;
            for (int f = 0; f < NFLT; f++)
                m_run[f] = act[f] ? ((m_run[f] >= 65535) ? 65535 : m_run[f] + 1) : 0;
            m_d2 = m_d1;
            m_d1 = fault_in;
        end
    endtask

    task automatic step(string name);
        model_edge();
        @(posedge clk);
        #1;
        chk(name, dut_vec(),
            mk_vec(m_oa, m_ob, (m_mode == M_TRIP) || (m_mode == M_CLR), m_cause, m_int));
    endtask

    typedef struct {
        bit             on, st, clr;
        logic [NCH-1:0] a, b, ea, eb;
        bit             etr;
        logic [NFLT:0]  ec;
        bit             ei;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h5A, 8'hA5, 8'h5A, 8'hA5, 1'b0, 5'b00000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h0F, 8'hF0, 8'h0F, 8'hF0, 1'b0, 5'b00000, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h08, 8'h08, 8'h08, 8'h08, 1'b0, 5'b00000, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h02, 8'h01, 8'h02, 1'b0, 5'b00000, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'h08, 8'h08, 8'hC3, 8'h3C, 1'b1, 5'b10000, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'hC3, 8'h3C, 1'b1, 5'b10000, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 8'hC3, 8'h3C, 1'b1, 5'b10000, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'hC3, 8'h3C, 8'hC3, 8'h3C, 1'b0, 5'b00000, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h77, 8'h88, 8'h77, 8'h88, 1'b0, 5'b00000, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 5'b00000, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h12, 8'h21, 8'h12, 8'h21, 1'b0, 5'b00000, 1'b0};

        reset = 1'b1; trip_onoff = 1'b0; st_onoff = 1'b0; clear_req = 1'b0;
        fault_in = '0; fault_pol = '0; fault_mask = '0; filt_len = '0;
        safe_A_x = 8'hC3; safe_B_x = 8'h3C; pwm_A_in_x = 8'hAA; pwm_B_in_x = 8'h55;
        step("reset");
        step("reset");
        chk("reset_const", dut_vec(), '0);

        reset = 1'b0; fault_pol = 4'hF; fault_mask = 4'hF; filt_len = 16'd3;
        for (int i = 0; i < 11; i++) begin
            trip_onoff = tbl[i].on; st_onoff = tbl[i].st; clear_req = tbl[i].clr;
            pwm_A_in_x = tbl[i].a;  pwm_B_in_x = tbl[i].b;
            step("tbl_model");
            chk($sformatf("tbl[%0d]", i), dut_vec(),
                mk_vec(tbl[i].ea, tbl[i].eb, tbl[i].etr, tbl[i].ec, tbl[i].ei));
        end

        // Debounce: a 4-cycle glitch must not trip, a 6-cycle pulse trips on edge 8.
        st_onoff = 1'b0; clear_req = 1'b0; fault_mask = '0; filt_len = 16'd5;
        for (int i = 1; i <= 12; i++) begin
            fault_in[0] = (i <= 4);
            step("glitch");
            chk1("glitch_notrip", tripped, 1'b0);
        end
        for (int i = 1; i <= 10; i++) begin
            fault_in[0] = (i <= 6);
            step("debounce");
            chk1($sformatf("deb_tripped@%0d", i), tripped, i >= 8);
            chk1($sformatf("deb_int@%0d", i), trip_int, i == 8);
        end
        chk("deb_cause", dut_vec(), mk_vec(8'hC3, 8'h3C, 1'b1, 5'b00001, 1'b0));

        // Clear is refused while the fault is still qualified.
        fault_in[0] = 1'b1;
        for (int i = 0; i < 9; i++) step("hold_fault");
        pwm_A_in_x = 8'hC3; pwm_B_in_x = 8'h3C; clear_req = 1'b1;
        step("clr_refused");
        clear_req = 1'b0;
        step("clr_refused2");
        chk1("clr_refused_tripped", tripped, 1'b1);
        fault_in[0] = 1'b0; pwm_A_in_x = 8'h11; pwm_B_in_x = 8'h22;
        for (int i = 0; i < 4; i++) step("release");
        clear_req = 1'b1;
        step("clr_accept");
        clear_req = 1'b0;
        step("clearing");
        step("clearing");
        chk("clearing_safe", dut_vec(), mk_vec(8'hC3, 8'h3C, 1'b1, 5'b00001, 1'b0));
        pwm_A_in_x = 8'hC3; pwm_B_in_x = 8'h3C;
        step("resume");
        chk("resume_armed", dut_vec(), mk_vec(8'hC3, 8'h3C, 1'b0, 5'b00000, 1'b0));
        pwm_A_in_x = 8'h55; pwm_B_in_x = 8'hAA;
        step("resume_pass");
        chk("resume_pass_const", dut_vec(), mk_vec(8'h55, 8'hAA, 1'b0, 5'b00000, 1'b0));

        // Masked fault filters but never trips; unmasking trips on the next edge.
        filt_len = 16'd2; fault_mask = 4'b0010; fault_in[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step("masked");
            chk1("masked_notrip", tripped, 1'b0);
        end
        fault_mask = '0;
        step("unmask");
        chk("unmask_trip", dut_vec(), mk_vec(8'hC3, 8'h3C, 1'b1, 5'b00010, 1'b1));

        // Reset drops the trip; then trip_onoff OFF returns to pass-through.
        reset = 1'b1;
        step("mid_reset");
        chk("mid_reset_const", dut_vec(), '0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step("retrip");
        chk1("retrip_tripped", tripped, 1'b1);
        trip_onoff = 1'b0; pwm_A_in_x = 8'h3E; pwm_B_in_x = 8'h41;
        step("off");
        chk("off_pass", dut_vec(), mk_vec(8'h3E, 8'h41, 1'b0, 5'b00000, 1'b0));
        fault_in = '0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 399) == 0);
            trip_onoff = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 49) == 0) filt_len = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0) fault_pol = 4'($urandom);
            if ($urandom_range(0, 29) == 0) fault_mask = 4'($urandom);
            for (int f = 0; f < NFLT; f++)
                if ($urandom_range(0, 7) == 0) fault_in[f] = ~fault_in[f];
            st_onoff  = ($urandom_range(0, 1) == 1);
            clear_req = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) begin
                pwm_A_in_x = safe_A_x; pwm_B_in_x = safe_B_x;
            end else begin
                pwm_A_in_x = 8'($urandom);
                pwm_B_in_x = ($urandom_range(0, 7) == 0) ? 8'($urandom) : ~pwm_A_in_x;
            end
            step("rand");
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
